// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory arbiter.
package mem_arb_pkg;

  // Which port owns the read response that arrives next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2,
    OWN_DBG  = 2'd3
  } owner_e;

  // Arbiter operating mode: RUN serves everyone, HALT serves only the host.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Read data returned for an out-of-range read.
  localparam logic [31:0] BAD_RDATA = 32'hDEAD_BEEF;

  // Bit positions inside the request / grant vectors.
  localparam int GNT_IF  = 0;
  localparam int GNT_LS  = 1;
  localparam int GNT_DBG = 2;

  // True when a byte address falls beyond the end of the RAM.
  function automatic logic is_oor(input logic [31:0] addr, input int unsigned mem_words);
    logic [32:0] limit;
    limit = 33'(mem_words) << 2;
    return ({1'b0, addr} >= limit);
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational 3-way priority picker: DBG > LS > IF, or DBG > IF > LS when
// the fetch port is starving. While halted only DBG can be granted.
module mem_arb_prio
  import mem_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic       starve,
  input  logic       halted,
  output logic [2:0] gnt
);

  // One-hot grant selection.
  always_comb begin
    gnt = 3'b000;
    if (req[GNT_DBG]) begin
      gnt[GNT_DBG] = 1'b1;
    end else if (halted) begin
      gnt = 3'b000;
    end else if (starve && req[GNT_IF]) begin
      gnt[GNT_IF] = 1'b1;
    end else if (req[GNT_LS]) begin
      gnt[GNT_LS] = 1'b1;
    end else if (req[GNT_IF]) begin
      gnt[GNT_IF] = 1'b1;
    end else begin
      gnt = 3'b000;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous RAM between CPU fetch, CPU load/store and
// a host debug port; detects the completion marker and provides a halt path.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_SIZE_WORDS = 1024,
  parameter int          ADDR_W         = 10,
  parameter logic [31:0] DONE_ADDR      = 32'h0000_0400,
  parameter logic [31:0] DONE_VALUE     = 32'h0000_0042,
  parameter int          STARVE_LIMIT   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic [31:0]       ls_addr,
  input  logic [31:0]       ls_wdata,
  input  logic [3:0]        ls_wen,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  input  logic              dbg_req,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_wdata,
  input  logic [3:0]        dbg_wen,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  input  logic              dbg_halt,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wen,
  input  logic [31:0]       mem_rdata,
  output logic              halted,
  output logic              done,
  output logic              err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  state_e        state;
  state_e        state_nxt;
  logic [SW-1:0] starve_cnt;
  logic          starve;
  owner_e        owner;
  logic          owner_oor;
  logic [2:0]    req_v;
  logic [2:0]    gnt;
  logic          accept;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [3:0]    sel_wen;
  owner_e        sel_own;
  logic          sel_oor;
  logic          sel_read;
  logic          done_set;
  logic [31:0]   resp_data;
  logic [31:0]   if_rdata_q;
  logic [31:0]   ls_rdata_q;
  logic [31:0]   dbg_rdata_q;

  // Requests are masked while reset is asserted so every output reads 0.
  assign req_v   = {dbg_req, ls_req, if_req} & {3{rst_n}};
  assign starve  = (starve_cnt == SW'(STARVE_LIMIT));
  assign halted  = (state == ST_HALT);

  mem_arb_prio u_prio (
    .req    (req_v),
    .starve (starve),
    .halted (halted),
    .gnt    (gnt)
  );

  assign if_gnt  = gnt[GNT_IF];
  assign ls_gnt  = gnt[GNT_LS];
  assign dbg_gnt = gnt[GNT_DBG];
  assign accept  = |gnt;

  // Route the granted port's request fields.
  always_comb begin
    sel_addr  = 32'h0000_0000;
    sel_wdata = 32'h0000_0000;
    sel_wen   = 4'b0000;
    sel_own   = OWN_NONE;
    case (gnt)
      3'b001:  begin sel_addr = if_addr;  sel_own = OWN_IF; end
      3'b010:  begin sel_addr = ls_addr;  sel_wdata = ls_wdata;  sel_wen = ls_wen;  sel_own = OWN_LS;  end
      3'b100:  begin sel_addr = dbg_addr; sel_wdata = dbg_wdata; sel_wen = dbg_wen; sel_own = OWN_DBG; end
      default: sel_own = OWN_NONE;
    endcase
  end

  assign sel_oor  = is_oor(sel_addr, MEM_SIZE_WORDS);
  assign sel_read = (sel_wen == 4'b0000);
  assign done_set = (gnt[GNT_LS] || gnt[GNT_DBG]) && (sel_wen == 4'b1111) &&
                    (sel_addr == DONE_ADDR) && (sel_wdata == DONE_VALUE);

  // Drive the RAM only for accepted in-range accesses; out-of-range writes vanish here.
  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'h0000_0000;
    mem_wen   = 4'b0000;
    if (accept && !sel_oor) begin
      mem_en    = 1'b1;
      mem_addr  = sel_addr[ADDR_W+1:2];
      mem_wdata = sel_wdata;
      mem_wen   = sel_wen;
    end else begin
      mem_en    = 1'b0;
    end
  end

  // Next-state logic: once done is set, only reset leaves HALT.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (done_set || done || dbg_halt) state_nxt = ST_HALT;
        else                              state_nxt = ST_RUN;
      end
      ST_HALT: begin
        if (!dbg_halt && !done && !done_set) state_nxt = ST_RUN;
        else                                 state_nxt = ST_HALT;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Mode register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Fetch starvation counter: counts consecutive denials, saturating, cleared on a fetch grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       starve_cnt <= '0;
    else if (if_gnt)                  starve_cnt <= '0;
    else if (if_req && !starve)       starve_cnt <= starve_cnt + SW'(1);
    else                              starve_cnt <= starve_cnt;
  end

  // Response owner and error pulse for the access accepted this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN_NONE;
      owner_oor <= 1'b0;
      err       <= 1'b0;
    end else begin
      owner     <= (accept && sel_read) ? sel_own : OWN_NONE;
      owner_oor <= accept && sel_oor;
      err       <= accept && sel_oor;
    end
  end

  assign resp_data = owner_oor ? BAD_RDATA : mem_rdata;

  // Per-port read data holding registers, refreshed only by that port's response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q  <= 32'h0000_0000;
      ls_rdata_q  <= 32'h0000_0000;
      dbg_rdata_q <= 32'h0000_0000;
    end else begin
      if (owner == OWN_IF)  if_rdata_q  <= resp_data;
      else                  if_rdata_q  <= if_rdata_q;
      if (owner == OWN_LS)  ls_rdata_q  <= resp_data;
      else                  ls_rdata_q  <= ls_rdata_q;
      if (owner == OWN_DBG) dbg_rdata_q <= resp_data;
      else                  dbg_rdata_q <= dbg_rdata_q;
    end
  end

  assign if_rvalid  = (owner == OWN_IF);
  assign ls_rvalid  = (owner == OWN_LS);
  assign dbg_rvalid = (owner == OWN_DBG);
  assign if_rdata   = if_rvalid  ? resp_data : if_rdata_q;
  assign ls_rdata   = ls_rvalid  ? resp_data : ls_rdata_q;
  assign dbg_rdata  = dbg_rvalid ? resp_data : dbg_rdata_q;

  // Sticky completion flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        done <= 1'b0;
    else if (done_set) done <= 1'b1;
    else               done <= done;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed table-driven bench for unified_mem_arbiter with a behavioural RAM.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, ls_req, dbg_req, dbg_halt;
  logic [31:0] if_addr, ls_addr, ls_wdata, dbg_addr, dbg_wdata;
  logic [3:0]  ls_wen, dbg_wen;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] if_rdata, ls_rdata, dbg_rdata;
  logic        mem_en, halted, done, err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_wen;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] ram [0:1023];

  always #5 clk = ~clk;

  unified_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wen(ls_wen),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_wen(dbg_wen),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_halt(dbg_halt),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_rdata(mem_rdata),
    .halted(halted), .done(done), .err(err)
  );

  // Behavioural single-port RAM, one-cycle read latency, byte write enables.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wen == 4'b0000) begin
        mem_rdata <= ram[mem_addr];
      end else begin
        for (int b = 0; b < 4; b++)
          if (mem_wen[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wen;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic [3:0]  dbg_wen;
    logic [2:0]  e_gnt;    // {dbg, ls, if}
    logic        e_en;
    logic [9:0]  e_addr;
    logic [3:0]  e_wen;
    logic [2:0]  e_rv;     // {dbg, ls, if}
    logic [1:0]  e_rsel;   // 1 IF, 2 LS, 3 DBG
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  localparam int NV = 12;
  vec_t vec [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    if_req = 1'b0; if_addr = 32'h0;
    ls_req = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_wen = 4'h0;
    dbg_req = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0; dbg_wen = 4'h0;
  endtask

  function automatic logic [31:0] port_rdata(input logic [1:0] sel);
    case (sel)
      2'd1:    return if_rdata;
      2'd2:    return ls_rdata;
      2'd3:    return dbg_rdata;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk_gnt(input string nm, input logic [2:0] e);
    chk(nm, 32'({dbg_gnt, ls_gnt, if_gnt}), 32'(e));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[0]    = 32'h0050_0093;
    ram[1]    = 32'h1111_1111;
    ram[2]    = 32'h2222_2222;
    ram[3]    = 32'h3333_3333;
    ram[1023] = 32'h7777_7777;
    mem_rdata = 32'h0;

    //          if  if_addr      ls  ls_addr      ls_wdata     lwen  dbg dbg_addr     dbg_wdata    dwen  gnt     en    addr      wen   rv      rsel  rdata         err
    vec[0]  = '{1'b1, 32'h0000, 1'b0, 32'h0000, 32'h0,        4'h0, 1'b0, 32'h0000, 32'h0,        4'h0, 3'b001, 1'b1, 10'd0,    4'h0, 3'b001, 2'd1, 32'h0050_0093, 1'b0};
    vec[1]  = '{1'b0, 32'h0000, 1'b1, 32'h1000, 32'h0,        4'h0, 1'b0, 32'h0000, 32'h0,        4'h0, 3'b010, 1'b0, 10'd0,    4'h0, 3'b010, 2'd2, 32'hDEAD_BEEF, 1'b1};
    vec[2]  = '{1'b0, 32'h0000, 1'b0, 32'h0000, 32'h0,        4'h0, 1'b0, 32'h0000, 32'h0,        4'h0, 3'b000, 1'b0, 10'd0,    4'h0, 3'b000, 2'd2, 32'hDEAD_BEEF, 1'b0};
    vec[3]  = '{1'b1, 32'h0008, 1'b1, 32'h0004, 32'h0,        4'h0, 1'b0, 32'h0000, 32'h0,        4'h0, 3'b010, 1'b1, 10'd1,    4'h0, 3'b010, 2'd2, 32'h1111_1111, 1'b0};
    vec[4]  = '{1'b1, 32'h0008, 1'b0, 32'h0000, 32'h0,        4'h0, 1'b0, 32'h0000, 32'h0,        4'h0, 3'b001, 1'b1, 10'd2,    4'h0, 3'b001, 2'd1, 32'h2222_2222, 1'b0};
    vec[5]  = '{1'b1, 32'h0000, 1'b1, 32'h0004, 32'h0,        4'h0, 1'b1, 32'h000C, 32'h0,        4'h0, 3'b100, 1'b1, 10'd3,    4'h0, 3'b100, 2'd3, 32'h3333_3333, 1'b0};
    vec[6]  = '{1'b0, 32'h0000, 1'b1, 32'h0010, 32'h0,        4'h0, 1'b1, 32'h0010, 32'hAAAA_5555, 4'hF, 3'b100, 1'b1, 10'd4,   4'hF, 3'b000, 2'd3, 32'h3333_3333, 1'b0};
    vec[7]  = '{1'b0, 32'h0000, 1'b1, 32'h0013, 32'h0,        4'h0, 1'b0, 32'h0000, 32'h0,        4'h0, 3'b010, 1'b1, 10'd4,    4'h0, 3'b010, 2'd2, 32'hAAAA_5555, 1'b0};
    vec[8]  = '{1'b0, 32'h0000, 1'b0, 32'h0000, 32'h0,        4'h0, 1'b1, 32'h0012, 32'h0000_00CC, 4'h1, 3'b100, 1'b1, 10'd4,   4'h1, 3'b000, 2'd1, 32'h2222_2222, 1'b0};
    vec[9]  = '{1'b0, 32'h0000, 1'b1, 32'h0010, 32'h0,        4'h0, 1'b0, 32'h0000, 32'h0,        4'h0, 3'b010, 1'b1, 10'd4,    4'h0, 3'b010, 2'd2, 32'hAAAA_55CC, 1'b0};
    vec[10] = '{1'b0, 32'h0000, 1'b0, 32'h0000, 32'h0,        4'h0, 1'b1, 32'h2000, 32'h1,        4'hF, 3'b100, 1'b0, 10'd0,    4'h0, 3'b000, 2'd3, 32'h3333_3333, 1'b1};
    vec[11] = '{1'b1, 32'h0FFC, 1'b0, 32'h0000, 32'h0,        4'h0, 1'b0, 32'h0000, 32'h0,        4'h0, 3'b001, 1'b1, 10'd1023, 4'h0, 3'b001, 2'd1, 32'h7777_7777, 1'b0};

    // Reset state
    idle();
    dbg_halt = 1'b0;
    rst_n    = 1'b0;
    #2;
    chk("reset gnt", 32'({dbg_gnt, ls_gnt, if_gnt}), 32'h0);
    chk("reset rvalid", 32'({dbg_rvalid, ls_rvalid, if_rvalid}), 32'h0);
    chk("reset flags", 32'({mem_en, halted, done, err}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table-driven single-cycle transactions
    for (int i = 0; i < NV; i++) begin
      if_req = vec[i].if_req; if_addr = vec[i].if_addr;
      ls_req = vec[i].ls_req; ls_addr = vec[i].ls_addr; ls_wdata = vec[i].ls_wdata; ls_wen = vec[i].ls_wen;
      dbg_req = vec[i].dbg_req; dbg_addr = vec[i].dbg_addr; dbg_wdata = vec[i].dbg_wdata; dbg_wen = vec[i].dbg_wen;
      @(negedge clk);
      chk_gnt($sformatf("v%0d gnt", i), vec[i].e_gnt);
      chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(vec[i].e_en));
      if (vec[i].e_en) begin
        chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vec[i].e_addr));
        chk($sformatf("v%0d mem_wen", i), 32'(mem_wen), 32'(vec[i].e_wen));
      end
      tick();
      chk($sformatf("v%0d rvalid", i), 32'({dbg_rvalid, ls_rvalid, if_rvalid}), 32'(vec[i].e_rv));
      chk($sformatf("v%0d rdata", i), port_rdata(vec[i].e_rsel), vec[i].e_rdata);
      chk($sformatf("v%0d err", i), 32'(err), 32'(vec[i].e_err));
      chk($sformatf("v%0d halted_done", i), 32'({halted, done}), 32'h0);
    end

    // Starvation: LS wins four times, IF on the fifth, then counter restarts
    idle();
    if_req = 1'b1; if_addr = 32'h4;
    ls_req = 1'b1; ls_addr = 32'h8;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk_gnt($sformatf("starve c%0d", c), (c == 4) ? 3'b001 : 3'b010);
      tick();
    end

    // Host writes win over CPU traffic, then halt and release
    idle();
    if_req = 1'b1; ls_req = 1'b1; ls_addr = 32'h4;
    dbg_req = 1'b1; dbg_wen = 4'hF;
    for (int k = 0; k < 3; k++) begin
      dbg_addr  = 32'h300 + 32'(4 * k);
      dbg_wdata = 32'(3 - k);
      @(negedge clk);
      chk_gnt($sformatf("dbgwr%0d gnt", k), 3'b100);
      tick();
    end
    dbg_req = 1'b0; dbg_wen = 4'h0; if_req = 1'b0; dbg_halt = 1'b1;
    @(negedge clk);
    chk_gnt("halt-edge gnt", 3'b010);
    tick();
    chk("halt halted", 32'(halted), 32'h1);
    chk("halt-edge ls_rvalid", 32'(ls_rvalid), 32'h1);
    chk("halt-edge ls_rdata", ls_rdata, 32'h1111_1111);
    if_req = 1'b1;
    @(negedge clk);
    chk_gnt("halted cpu gnt", 3'b000);
    tick();
    dbg_req = 1'b1; dbg_addr = 32'h304;
    @(negedge clk);
    chk_gnt("halted dbg gnt", 3'b100);
    tick();
    chk("halted dbg rdata", dbg_rdata, 32'h2);
    chk("halted dbg rvalid", 32'(dbg_rvalid), 32'h1);
    idle();
    dbg_halt = 1'b0;
    tick();
    chk("release halted", 32'(halted), 32'h0);

    // Completion marker
    ls_req = 1'b1; ls_addr = 32'h400; ls_wdata = 32'h42; ls_wen = 4'hF;
    @(negedge clk);
    chk_gnt("done wr gnt", 3'b010);
    chk("done wr mem", 32'({mem_en, 2'b00, mem_addr, mem_wen}), 32'({1'b1, 2'b00, 10'd256, 4'hF}));
    chk("done wr wdata", mem_wdata, 32'h42);
    tick();
    chk("done flags", 32'({halted, done}), 32'h3);
    idle();
    if_req = 1'b1;
    @(negedge clk);
    chk_gnt("done if gnt", 3'b000);
    tick();
    idle();
    dbg_req = 1'b1; dbg_addr = 32'h400;
    @(negedge clk);
    chk_gnt("done dbg gnt", 3'b100);
    tick();
    chk("done dbg rvalid", 32'(dbg_rvalid), 32'h1);
    chk("done dbg rdata", dbg_rdata, 32'h42);
    chk("done still halted", 32'(halted), 32'h1);

    // Reset with a read response pending
    idle();
    dbg_halt = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    ls_req = 1'b1; ls_addr = 32'h4;
    @(negedge clk);
    chk_gnt("pre-reset gnt", 3'b010);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst gnt rvalid", 32'({dbg_gnt, ls_gnt, if_gnt, dbg_rvalid, ls_rvalid, if_rvalid}), 32'h0);
    chk("rst rdata", if_rdata | ls_rdata | dbg_rdata, 32'h0);
    chk("rst mem", 32'({mem_en, mem_addr, mem_wen}) | mem_wdata, 32'h0);
    chk("rst flags", 32'({halted, done, err}), 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    ls_req = 1'b0;
    tick();
    chk("post-reset ls_rvalid", 32'(ls_rvalid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
